// File: rtl/register_bank_pkg.sv
// register_bank_pkg
//   Shared opcode encoding and helpers for register_bank and its cells.
//   RB_CTRL_WIDTH : width of the opcode bus
//   rb_ctrl_e     : opcode values; 11..15 are reserved and behave as NOP
//   rb_is_channel_op() : true for ops that act only on the selected channel
package register_bank_pkg;

    localparam int RB_CTRL_WIDTH = 4;

    typedef enum logic [RB_CTRL_WIDTH-1:0] {
        RB_CTRL_NOP     = 4'd0,
        RB_CTRL_INC     = 4'd1,
        RB_CTRL_DEC     = 4'd2,
        RB_CTRL_LD      = 4'd3,
        RB_CTRL_CLR     = 4'd4,
        RB_CTRL_SHL     = 4'd5,
        RB_CTRL_SHR     = 4'd6,
        RB_CTRL_ROL     = 4'd7,
        RB_CTRL_ROR     = 4'd8,
        RB_CTRL_CLR_ALL = 4'd9,
        RB_CTRL_LD_ALL  = 4'd10
    } rb_ctrl_e;

    function automatic logic rb_is_channel_op(input logic [RB_CTRL_WIDTH-1:0] op);
        return (op >= RB_CTRL_INC) && (op <= RB_CTRL_ROR);
    endfunction

endpackage

// File: rtl/register_bank_cell.sv
// register_bank_cell
//   One WIDTH-bit channel of the bank. Per-channel ops apply only while
//   i_en is high; bank-wide ops (CLR_ALL, LD_ALL) apply regardless.
//   Ports:
//     clk          : system clock, rising edge
//     async_reset  : asynchronous reset, active-high, clears the channel
//     i_en         : this channel is the target of a per-channel op
//     i_ctrl       : opcode
//     i_data       : load value for LD / LD_ALL
//     i_serial     : fill bit for SHL / SHR
//     o_value      : stored channel value
//     o_carry_next : carry/borrow/shifted-out bit the current op produces
//     o_zero       : stored value is zero
module register_bank_cell
    import register_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic                     clk,
    input  logic                     async_reset,
    input  logic                     i_en,
    input  logic [RB_CTRL_WIDTH-1:0] i_ctrl,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_serial,
    output logic [WIDTH-1:0]         o_value,
    output logic                     o_carry_next,
    output logic                     o_zero
);

    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_next;
    logic             w_carry;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic             w_chan_op;

    // WIDTH+1-bit results: top bit is carry-out for INC and borrow for DEC.
    assign w_inc     = {1'b0, r_value} + {{WIDTH{1'b0}}, 1'b1};
    assign w_dec     = {1'b0, r_value} - {{WIDTH{1'b0}}, 1'b1};
    assign w_chan_op = i_en && rb_is_channel_op(i_ctrl);

    always_comb begin
        w_next  = r_value;
        w_carry = 1'b0;
        if (w_chan_op) begin
            case (i_ctrl)
                RB_CTRL_INC: begin
                    w_carry = w_inc[WIDTH];
                    w_next  = ((SATURATE != 0) && w_inc[WIDTH]) ? {WIDTH{1'b1}}
                                                                 : w_inc[WIDTH-1:0];
                end
                RB_CTRL_DEC: begin
                    w_carry = w_dec[WIDTH];
                    w_next  = ((SATURATE != 0) && w_dec[WIDTH]) ? {WIDTH{1'b0}}
                                                                 : w_dec[WIDTH-1:0];
                end
                RB_CTRL_LD: begin
                    w_next = i_data;
                end
                RB_CTRL_CLR: begin
                    w_next = '0;
                end
                RB_CTRL_SHL: begin
                    w_carry = r_value[WIDTH-1];
                    w_next  = {r_value[WIDTH-2:0], i_serial};
                end
                RB_CTRL_SHR: begin
                    w_carry = r_value[0];
                    w_next  = {i_serial, r_value[WIDTH-1:1]};
                end
                RB_CTRL_ROL: begin
                    w_carry = r_value[WIDTH-1];
                    w_next  = {r_value[WIDTH-2:0], r_value[WIDTH-1]};
                end
                RB_CTRL_ROR: begin
                    w_carry = r_value[0];
                    w_next  = {r_value[0], r_value[WIDTH-1:1]};
                end
                default: begin
                    w_next  = r_value;
                    w_carry = 1'b0;
                end
            endcase
        end else if (i_ctrl == RB_CTRL_CLR_ALL) begin
            w_next = '0;
        end else if (i_ctrl == RB_CTRL_LD_ALL) begin
            w_next = i_data;
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_value <= '0;
        end else begin
            r_value <= w_next;
        end
    end

    assign o_value      = r_value;
    assign o_carry_next = w_carry;
    assign o_zero       = (r_value == '0);

endmodule

// File: rtl/register_bank.sv
// register_bank
//   Bank of CHANNELS independent WIDTH-bit registers sharing one opcode bus.
//   Per-channel ops act on channel sel; CLR_ALL / LD_ALL act on every channel.
//   Ports:
//     clk          : system clock, rising edge
//     async_reset  : asynchronous reset, active-high
//     ctrl         : opcode, sampled each rising edge
//     sel          : target channel for per-channel ops
//     data_input   : load value for LD / LD_ALL
//     serial_in    : fill bit for SHL / SHR
//     data_output  : all channels, channel i at [i*WIDTH +: WIDTH]
//     sel_output   : stored value of channel sel, 0 when sel >= CHANNELS
//     zero         : bit i set when channel i holds 0
//     carry        : registered carry/borrow/shifted-out bit of the last op
module register_bank
    import register_bank_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int SEL_WIDTH = 2,
    parameter int SATURATE  = 0
) (
    input  logic                      clk,
    input  logic                      async_reset,
    input  logic [RB_CTRL_WIDTH-1:0]  ctrl,
    input  logic [SEL_WIDTH-1:0]      sel,
    input  logic [WIDTH-1:0]          data_input,
    input  logic                      serial_in,
    output logic [CHANNELS*WIDTH-1:0] data_output,
    output logic [WIDTH-1:0]          sel_output,
    output logic [CHANNELS-1:0]       zero,
    output logic                      carry
);

    // Every sel code gets a slot; slots beyond CHANNELS read as zero with no
    // carry, so an out-of-range select needs no separate range check.
    localparam int SLOTS = 1 << SEL_WIDTH;

    logic [WIDTH-1:0] w_slot_value [SLOTS];
    logic [SLOTS-1:0] w_slot_carry;
    logic             r_carry;

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        if (g < CHANNELS) begin : g_cell
            logic w_en;
            assign w_en = (sel == SEL_WIDTH'(g));

            register_bank_cell #(
                .WIDTH    (WIDTH),
                .SATURATE (SATURATE)
            ) u_cell (
                .clk          (clk),
                .async_reset  (async_reset),
                .i_en         (w_en),
                .i_ctrl       (ctrl),
                .i_data       (data_input),
                .i_serial     (serial_in),
                .o_value      (w_slot_value[g]),
                .o_carry_next (w_slot_carry[g]),
                .o_zero       (zero[g])
            );

            assign data_output[g*WIDTH +: WIDTH] = w_slot_value[g];
        end else begin : g_empty
            assign w_slot_value[g] = '0;
            assign w_slot_carry[g] = 1'b0;
        end
    end

    assign sel_output = w_slot_value[sel];

    // Only the selected cell can raise carry, and only for a per-channel op.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_carry <= 1'b0;
        end else begin
            r_carry <= w_slot_carry[sel];
        end
    end

    assign carry = r_carry;

endmodule
